sp_ram_be: RTL and testbench
============================

# sp_ram_be

Parametrised single-port synchronous RAM with a valid/ready request interface, per-byte write enables, a registered one-cycle read response, out-of-range address detection and a hardware clear sequencer. It replaces the fixed 8-bit × 1024-word `ram` as the general storage block for datapaths that need wider words, non-power-of-two depth, or guaranteed zeroed contents after reset.

## Interface
- `DATA_W`, 8: word width in bits; must be a multiple of 8.
- `ADDR_W`, 10: address width in bits.
- `DEPTH`, 1024: number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- `INIT_VAL`, 0: DATA_W-bit value written to every word by the clear sequencer.
- Derived: `BE_W` = DATA_W/8.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `init_start` in 1: a one-cycle pulse that requests a full clear.
- `init_busy` out 1: high while the clear sequencer runs.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid` && `req_ready` at a clock edge.
- `req_rw` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `req_be` in BE_W: byte enables; bit i covers `req_wdata[8i+7:8i]`.
- `rsp_valid` out 1: one-cycle pulse indicating a read result.
- `rsp_rdata` out DATA_W: read data, valid when `rsp_valid` is high.
- `rsp_err` out 1: high with `rsp_valid` when the read address ≥ DEPTH.
- `wr_err` out 1: one-cycle pulse after an accepted write with address ≥ DEPTH.

## Operation
- FSM states are CLEAR and IDLE.
- While `rst_n` is low: state = CLEAR, clear counter = 0, `req_ready`=0, `init_busy`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `wr_err`=0. Array contents are not reset by flops.
- CLEAR: each cycle writes INIT_VAL to word[counter], then the counter increments. After word DEPTH-1 is written, the counter returns to 0 and the state moves to IDLE. `init_busy`=1 and `req_ready`=0 throughout.
- IDLE: `req_ready` = !`init_start` (combinational). An `init_start` pulse in IDLE moves the state to CLEAR with counter = 0. `init_start` has priority over a simultaneous request; that request is not accepted. `init_start` pulses while in CLEAR are ignored and do not restart the clear.
- Accepted write, in range: for each i with `req_be[i]`=1, byte i of word[addr] takes the corresponding byte of `req_wdata`. Bytes with `req_be[i]`=0 are unchanged. A write with all enables low is legal and is a no-op.
- Accepted write, out of range: the array is unchanged and `wr_err` pulses on the next cycle.
- Accepted read: on the next cycle `rsp_valid`=1 and `rsp_rdata`=word[addr]. If addr ≥ DEPTH, `rsp_rdata`=0 and `rsp_err`=1.
- The response path has no backpressure. `rsp_valid`, `rsp_err` and `wr_err` are single-cycle pulses. `rsp_rdata` holds its value until the next read response.
- A read accepted in the last IDLE cycle before an `init_start` still returns pre-clear data.
- Reset asserted mid-clear or mid-access aborts it immediately. After release the clear restarts from word 0; any pending response is dropped.

## Timing
- After `rst_n` rises, edge k (k = 1..DEPTH) writes word k-1. `init_busy` falls and `req_ready` rises after edge DEPTH, so the clear takes exactly DEPTH cycles.
- Throughput is one request per cycle in IDLE, reads and writes back to back in any mix.
- Read latency is 1 cycle from the accepting edge to `rsp_valid`.
- Write followed by a read of the same address on the next cycle returns the new data (no bypass is needed; the write is committed at the accepting edge).
- The `init_start` clear takes DEPTH cycles from the edge that samples it. `req_ready` is low from that cycle on.

## Test plan
- Reset release, defaults: count cycles until `req_ready`=1, expect 1024 with `init_busy` high during that interval. Then read addresses 0, 1 and 1023 and expect `rsp_rdata`=0x00 one cycle after each accept.
- Back-to-back write/read: write 0x03@0x000, 0x01@0x001, 0x00@0x002 on consecutive cycles, then read 0, 1, 2 on consecutive cycles. Expect `rsp_valid` on three consecutive cycles with 0x03, 0x01, 0x00.
- DATA_W=32: write 0xAABBCCDD@5 with be=4'hF, then 0x11223344@5 with be=4'b0101. Reading 5 must return 0xAA22CC44.
- DEPTH=1000, ADDR_W=10:
  - Write 0x55@1000 gives a `wr_err` pulse, and word 0 is unchanged.
  - Read @1023 gives `rsp_err`=1, `rsp_rdata`=0.
  - Read @999 gives `rsp_err`=0.
- Reset mid-clear, DEPTH=16: pull `rst_n` low at clear cycle 7. After release, expect `init_busy` high for exactly 16 cycles again.
- `init_start` with `req_valid`=1 (write 0x7F@3) in the same IDLE cycle: the write is not accepted and `init_busy` rises. After the clear, reading @3 returns INIT_VAL.

Source files
------------

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM with per-byte write enables, a one-cycle registered
// read response, out-of-range detection and a hardware clear sequencer.
module sp_ram_be #(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        ADDR_W   = 10,
  parameter int unsigned        DEPTH    = 1024,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_start,
  output logic                  init_busy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  wr_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_range;
  logic                acc;
  logic                last_clr;
  logic [IDX_W-1:0]    req_idx;
  logic [DATA_W-1:0]   wr_word;

  // Extra MSB keeps the range check exact when DEPTH == 2**ADDR_W.
  assign in_range  = ({1'b0, req_addr} < CMP_W'(DEPTH));
  assign req_ready = (state == ST_IDLE) && !init_start;
  assign acc       = req_valid && req_ready;
  assign last_clr  = (clr_cnt == ADDR_W'(DEPTH - 1));
  assign req_idx   = IDX_W'(req_addr);

  // Byte-merge of the write data into the currently stored word.
  always_comb begin
    wr_word = mem[req_idx];
    for (int i = 0; i < BE_W; i++) begin
      if (req_be[i]) begin
        wr_word[8*i +: 8] = req_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      wr_err    <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (last_clr) begin
            clr_cnt   <= '0;
            state     <= ST_IDLE;
            init_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        ST_IDLE: begin
          if (init_start) begin
            state     <= ST_CLEAR;
            clr_cnt   <= '0;
            init_busy <= 1'b1;
          end else if (acc) begin
            if (req_rw) begin
              wr_err <= !in_range;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= !in_range;
              rsp_rdata <= in_range ? mem[req_idx] : '0;
            end
          end
        end
        default: begin
          state     <= ST_CLEAR;
          clr_cnt   <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  // Storage array: no reset; the clear sequencer owns initialisation.
  always_ff @(posedge clk) begin
    if (rst_n && (state == ST_CLEAR)) begin
      mem[IDX_W'(clr_cnt)] <= INIT_VAL;
    end else if (acc && req_rw && in_range) begin
      mem[req_idx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_sp_ram_be.sv
// Randomised self-checking bench for sp_ram_be (32-bit words, 1000-word depth)
// against an array-based reference model of the memory and clear timing.
module tb_sp_ram_be;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1000;
  localparam int unsigned BW    = DW / 8;
  localparam logic [DW-1:0] INIT = 32'h5A5A_0F0F;

  logic          clk;
  logic          rst_n;
  logic          init_start;
  logic          init_busy;
  logic          req_valid;
  logic          req_ready;
  logic          req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          wr_err;

  int            n_chk;
  int            n_fail;
  logic [DW-1:0] model [DEPTH];
  int            busy_left;
  logic [DW-1:0] last_rdata;

  sp_ram_be #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .INIT_VAL (INIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_start (init_start),
    .init_busy  (init_busy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_fill_init();
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
  endtask

  // One clock of stimulus; predicts and checks ready/busy now and the response after the edge.
  task automatic cycle(input logic v, input logic rw, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [BW-1:0] be, input logic ini);
    logic          exp_rdy;
    logic          e_rv;
    logic          e_err;
    logic          e_werr;
    logic [DW-1:0] mask;
    req_valid  = v;
    req_rw     = rw;
    req_addr   = a;
    req_wdata  = wd;
    req_be     = be;
    init_start = ini;
    #1;
    exp_rdy = (busy_left == 0) && !ini;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("init_busy", 32'(init_busy), 32'(busy_left != 0));
    e_rv   = 1'b0;
    e_err  = 1'b0;
    e_werr = 1'b0;
    if (busy_left > 0) begin
      busy_left--;
    end else if (ini) begin
      busy_left = DEPTH;
      model_fill_init();
    end else if (v) begin
      if (rw) begin
        if (int'(a) >= DEPTH) begin
          e_werr = 1'b1;
        end else begin
          mask = '0;
          for (int i = 0; i < BW; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
          model[a] = (model[a] & ~mask) | (wd & mask);
        end
      end else begin
        e_rv = 1'b1;
        if (int'(a) >= DEPTH) begin
          e_err      = 1'b1;
          last_rdata = '0;
        end else begin
          last_rdata = model[a];
        end
      end
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("wr_err", 32'(wr_err), 32'(e_werr));
    chk("rsp_rdata", rsp_rdata, last_rdata);
  endtask

  // Counts edges until req_ready rises, bounded so a stuck clear still reaches the summary.
  task automatic wait_clear();
    int   n;
    logic bad;
    n   = 0;
    bad = 1'b0;
    req_valid  = 1'b0;
    init_start = 1'b0;
    for (int k = 0; k < 4 * DEPTH; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (req_ready) break;
      if (!init_busy) bad = 1'b1;
    end
    chk("clear_cycles", 32'(n), 32'(DEPTH));
    chk("busy_during_clear", 32'(bad), 32'd0);
    chk("busy_after_clear", 32'(init_busy), 32'd0);
    busy_left = 0;
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    init_start = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    busy_left  = DEPTH;
    last_rdata = '0;
    model_fill_init();
    wait_clear();
  endtask

  initial begin
    logic [AW-1:0] ra;
    n_chk      = 0;
    n_fail     = 0;
    clk        = 1'b0;
    rst_n      = 1'b1;
    init_start = 1'b0;
    req_valid  = 1'b0;
    req_rw     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    busy_left  = 0;
    last_rdata = '0;
    #2;
    apply_reset();

    // Freshly cleared words read back as INIT.
    cycle(1'b1, 1'b0, 10'd0,   32'h0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 10'd1,   32'h0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 10'd999, 32'h0, 4'h0, 1'b0);

    // Back-to-back writes then reads.
    cycle(1'b1, 1'b1, 10'd0, 32'h03, 4'hF, 1'b0);
    cycle(1'b1, 1'b1, 10'd1, 32'h01, 4'hF, 1'b0);
    cycle(1'b1, 1'b1, 10'd2, 32'h00, 4'hF, 1'b0);
    cycle(1'b1, 1'b0, 10'd0, 32'h0,  4'h0, 1'b0);
    cycle(1'b1, 1'b0, 10'd1, 32'h0,  4'h0, 1'b0);
    cycle(1'b1, 1'b0, 10'd2, 32'h0,  4'h0, 1'b0);

    // Partial byte enables.
    cycle(1'b1, 1'b1, 10'd5, 32'hAABB_CCDD, 4'hF,    1'b0);
    cycle(1'b1, 1'b1, 10'd5, 32'h1122_3344, 4'b0101, 1'b0);
    cycle(1'b1, 1'b0, 10'd5, 32'h0,         4'h0,    1'b0);
    chk("be_merge", rsp_rdata, 32'hAA22_CC44);

    // All-disabled write is a no-op; write-then-read on consecutive cycles.
    cycle(1'b1, 1'b1, 10'd2, 32'hFFFF_FFFF, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 10'd2, 32'h0,         4'h0, 1'b0);

    // Out-of-range accesses.
    cycle(1'b1, 1'b1, 10'd1000, 32'h55, 4'hF, 1'b0);
    cycle(1'b1, 1'b0, 10'd0,    32'h0,  4'h0, 1'b0);
    cycle(1'b1, 1'b0, 10'd1023, 32'h0,  4'h0, 1'b0);
    cycle(1'b1, 1'b0, 10'd999,  32'h0,  4'h0, 1'b0);

    // Read just before init_start returns pre-clear data; a colliding write is dropped.
    cycle(1'b1, 1'b0, 10'd5, 32'h0,  4'h0, 1'b0);
    cycle(1'b1, 1'b1, 10'd3, 32'h7F, 4'hF, 1'b1);
    for (int k = 0; k < DEPTH; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 999)),
            $urandom, 4'($urandom_range(0, 15)), 1'(k % 97 == 3));
    end
    cycle(1'b1, 1'b0, 10'd3, 32'h0, 4'h0, 1'b0);
    chk("after_init", rsp_rdata, INIT);

    // Reset partway through a clear restarts it from word 0.
    cycle(1'b1, 1'b1, 10'd7, 32'h1234_5678, 4'hF, 1'b0);
    cycle(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b1);
    repeat (7) cycle(1'b0, 1'b0, 10'd0, 32'h0, 4'h0, 1'b0);
    apply_reset();
    cycle(1'b1, 1'b0, 10'd7, 32'h0, 4'h0, 1'b0);

    // Random mix of reads, writes, out-of-range and occasional clears.
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 9))
        0:       ra = 10'($urandom_range(1000, 1023));
        1, 2, 3: ra = 10'($urandom_range(0, 999));
        default: ra = 10'($urandom_range(0, 15));
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 499) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
